// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer blocks: FSM encoding and BCD preset clamps.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX = 3'd5;

  // Out-of-range presets saturate to the largest legal digit.
  function automatic logic [3:0] clamp_ones(input logic [3:0] v);
    return (v > ONES_MAX) ? ONES_MAX : v;
  endfunction

  function automatic logic [2:0] clamp_tens(input logic [2:0] v);
    return (v > TENS_MAX) ? TENS_MAX : v;
  endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler: counts CLK_FREQ cycles while enabled and pulses TICK on the last one.
module tick_gen #(
  parameter int CLK_FREQ = 125_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic TICK
);

  localparam int W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_FREQ - 1);

  logic [W-1:0] cnt;

  // Dropping EN clears the count, so re-enabling always starts a full period.
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign TICK = EN && (cnt == LAST);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS-style seconds countdown (00-59) with pause, expiry pulse and a timed alarm.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int CLK_FREQ  = 125_000_000,
  parameter int ALARM_SEC = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [3:0] SET_1S,
  input  logic [2:0] SET_10S,
  input  logic       START,
  output logic [3:0] NUM_1S,
  output logic [2:0] NUM_10S,
  output logic       RUNNING,
  output logic       DONE,
  output logic       ALARM,
  output state_t     state_dbg
);

  localparam int AW = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   alarm_cnt_q, alarm_cnt_d;
  logic [3:0]      ones_d;
  logic [2:0]      tens_d;
  logic            done_d;
  logic            tick_en;
  logic            tick;

  // Prescaler runs only while counting down or timing the alarm; a pause or a
  // load drops the enable in the same cycle so the prescaler restarts from zero.
  assign tick_en = ((state_q == ST_RUN) && START) || ((state_q == ST_ALARM) && !LOAD);

  tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (tick_en),
    .TICK (tick)
  );

  always_comb begin
    state_d     = state_q;
    ones_d      = NUM_1S;
    tens_d      = NUM_10S;
    alarm_cnt_d = alarm_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (LOAD) begin
          ones_d = clamp_ones(SET_1S);
          tens_d = clamp_tens(SET_10S);
        end else if (START && ((NUM_1S != 4'd0) || (NUM_10S != 3'd0))) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // START low wins over a coincident tick: no decrement on the way to PAUSE.
        if (!START) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          if (NUM_1S == 4'd0) begin
            ones_d = 4'd9;
            tens_d = NUM_10S - 3'd1;
          end else begin
            ones_d = NUM_1S - 4'd1;
            if ((NUM_1S == 4'd1) && (NUM_10S == 3'd0)) begin
              done_d      = 1'b1;
              state_d     = ST_ALARM;
              alarm_cnt_d = '0;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (LOAD) begin
          ones_d  = clamp_ones(SET_1S);
          tens_d  = clamp_tens(SET_10S);
          state_d = ST_IDLE;
        end else if (START) begin
          state_d = ST_RUN;
        end
      end
      ST_ALARM: begin
        if (LOAD) begin
          ones_d      = clamp_ones(SET_1S);
          tens_d      = clamp_tens(SET_10S);
          alarm_cnt_d = '0;
          state_d     = ST_IDLE;
        end else if (tick) begin
          if (alarm_cnt_q == ALARM_LAST) begin
            alarm_cnt_d = '0;
            state_d     = ST_IDLE;
          end else begin
            alarm_cnt_d = alarm_cnt_q + AW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      alarm_cnt_q <= '0;
      NUM_1S      <= 4'd0;
      NUM_10S     <= 3'd0;
      RUNNING     <= 1'b0;
      DONE        <= 1'b0;
      ALARM       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alarm_cnt_q <= alarm_cnt_d;
      NUM_1S      <= ones_d;
      NUM_10S     <= tens_d;
      RUNNING     <= (state_d == ST_RUN);
      DONE        <= done_d;
      ALARM       <= (state_d == ST_ALARM);
    end
  end

  assign state_dbg = state_q;

endmodule
